// File: rtl/ascon_perm_sequencer_pkg.sv
// Shared constants, FSM encoding and helpers for the iterative Ascon permutation engine.
package ascon_perm_sequencer_pkg;

    localparam logic [1:0] RSEL_P12    = 2'b00;
    localparam logic [1:0] RSEL_P8     = 2'b01;
    localparam logic [1:0] RSEL_P6     = 2'b10;
    localparam int         NROUNDS_MAX = 12;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } seq_state_t;

    // x0 occupies the most significant word
    typedef struct packed {
        logic [63:0] x0;
        logic [63:0] x1;
        logic [63:0] x2;
        logic [63:0] x3;
        logic [63:0] x4;
    } ascon_state_t;

    function automatic logic [63:0] ascon_rc(input logic [3:0] r);
        return {56'b0, 4'd15 - r, r};
    endfunction

    // Shorter permutations run the tail of the p12 schedule; sel=11 aliases p12
    function automatic logic [3:0] ascon_start_idx(input logic [1:0] sel);
        case (sel)
            RSEL_P8: return 4'd4;
            RSEL_P6: return 4'd6;
            default: return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/ascon_perm_sequencer_if.sv
// Request/result bus between the mode controller (master) and the permutation engine (slave).
interface ascon_perm_sequencer_if;
    // Both channels are valid/ready: a transfer happens on a rising clk edge where
    // valid and ready are both high; valid and its payload hold until that edge.
    logic        in_valid_i;
    logic        in_ready_o;
    logic [1:0]  rounds_sel_i;
    logic [63:0] x0_i, x1_i, x2_i, x3_i, x4_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [63:0] x0_o, x1_o, x2_o, x3_o, x4_o;
    logic        busy_o;

    modport master (
        output in_valid_i, rounds_sel_i, x0_i, x1_i, x2_i, x3_i, x4_i, out_ready_i,
        input  in_ready_o, out_valid_o, x0_o, x1_o, x2_o, x3_o, x4_o, busy_o
    );

    modport slave (
        input  in_valid_i, rounds_sel_i, x0_i, x1_i, x2_i, x3_i, x4_i, out_ready_i,
        output in_ready_o, out_valid_o, x0_o, x1_o, x2_o, x3_o, x4_o, busy_o
    );
endinterface

// File: rtl/ascon_perm_sequencer_round.sv
// One Ascon round: constant addition, 5-bit S-box layer (bitsliced), linear diffusion.
module ascon_permutation_1p
    import ascon_perm_sequencer_pkg::*;
(
    input  ascon_state_t s_in,
    input  logic [63:0]  round_const,
    output ascon_state_t s_out
);

    function automatic logic [63:0] ror(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    logic [63:0] a0, a1, a2, a3, a4;
    logic [63:0] t0, t1, t2, t3, t4;

    always_comb begin
        a0 = s_in.x0;
        a1 = s_in.x1;
        a2 = s_in.x2 ^ round_const;
        a3 = s_in.x3;
        a4 = s_in.x4;
        a0 = a0 ^ a4;
        a4 = a4 ^ a3;
        a2 = a2 ^ a1;
        t0 = ~a0 & a1;
        t1 = ~a1 & a2;
        t2 = ~a2 & a3;
        t3 = ~a3 & a4;
        t4 = ~a4 & a0;
        a0 = a0 ^ t1;
        a1 = a1 ^ t2;
        a2 = a2 ^ t3;
        a3 = a3 ^ t4;
        a4 = a4 ^ t0;
        a1 = a1 ^ a0;
        a0 = a0 ^ a4;
        a3 = a3 ^ a2;
        a2 = ~a2;
        s_out.x0 = a0 ^ ror(a0, 19) ^ ror(a0, 28);
        s_out.x1 = a1 ^ ror(a1, 61) ^ ror(a1, 39);
        s_out.x2 = a2 ^ ror(a2, 1)  ^ ror(a2, 6);
        s_out.x3 = a3 ^ ror(a3, 10) ^ ror(a3, 17);
        s_out.x4 = a4 ^ ror(a4, 7)  ^ ror(a4, 41);
    end

endmodule

// File: rtl/ascon_perm_sequencer.sv
// Iterative Ascon p12/p8/p6 engine: a 320-bit state register looped through UNROLL chained rounds.
module ascon_perm_sequencer
    import ascon_perm_sequencer_pkg::*;
#(
    parameter int UNROLL = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    ascon_perm_sequencer_if.slave bus,
    output logic [1:0]            fsm_state
);

    seq_state_t   state;
    ascon_state_t st_q;
    logic [3:0]   rc_idx;
    logic         ready_q, out_valid_q, busy_q;
    ascon_state_t chain [UNROLL+1];
    logic         last_step;

    assign chain[0] = st_q;

    // Instance k applies round rc_idx+k
    for (genvar k = 0; k < UNROLL; k++) begin : g_round
        logic [63:0] rc_k;
        assign rc_k = ascon_rc(rc_idx + 4'(k));
        ascon_permutation_1p u_round (
            .s_in        (chain[k]),
            .round_const (rc_k),
            .s_out       (chain[k+1])
        );
    end

    assign last_step = (rc_idx + 4'(UNROLL)) == 4'(NROUNDS_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            rc_idx      <= 4'd0;
            st_q        <= '0;
            ready_q     <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid_i) begin
                        st_q    <= {bus.x0_i, bus.x1_i, bus.x2_i, bus.x3_i, bus.x4_i};
                        rc_idx  <= ascon_start_idx(bus.rounds_sel_i);
                        state   <= S_RUN;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                S_RUN: begin
                    st_q   <= chain[UNROLL];
                    rc_idx <= rc_idx + 4'(UNROLL);
                    if (last_step) begin
                        state       <= S_DONE;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    // Returning through IDLE keeps a request from starting in the handoff cycle
                    if (bus.out_ready_i) begin
                        state       <= S_IDLE;
                        out_valid_q <= 1'b0;
                        ready_q     <= 1'b1;
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    ready_q     <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready_o  = ready_q & ~rst;
    assign bus.out_valid_o = out_valid_q;
    assign bus.busy_o      = busy_q;
    assign bus.x0_o        = st_q.x0;
    assign bus.x1_o        = st_q.x1;
    assign bus.x2_o        = st_q.x2;
    assign bus.x3_o        = st_q.x3;
    assign bus.x4_o        = st_q.x4;
    assign fsm_state       = state;

endmodule

// File: tb/tb_ascon_perm_sequencer.sv
// Scoreboard bench for ascon_perm_sequencer, driving an UNROLL=1 and an UNROLL=2 instance side by side.
module tb_ascon_perm_sequencer;

    localparam int W = 320;
    typedef logic [4:0][63:0] gst_t;  // element i holds word xi

    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    ascon_perm_sequencer_if bi1();
    ascon_perm_sequencer_if bi2();
    logic [1:0] st1, st2;

    ascon_perm_sequencer #(.UNROLL(1)) dut1 (.clk(clk), .rst(rst), .bus(bi1), .fsm_state(st1));
    ascon_perm_sequencer #(.UNROLL(2)) dut2 (.clk(clk), .rst(rst), .bus(bi2), .fsm_state(st2));

    // scoreboard
    logic [W-1:0] exp_q1[$], exp_q2[$];
    int lat_q1[$], lat_q2[$], acc_q1[$], acc_q2[$];
    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // golden model: table-driven S-box over bit columns
    function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
        logic [127:0] d;
        d = {v, v} >> n;
        return d[63:0];
    endfunction

    function automatic gst_t g_round(input gst_t s, input int r);
        gst_t o;
        logic [4:0] col, sb;
        s[2] = s[2] ^ 64'((15 - r) * 16 + r);
        for (int j = 0; j < 64; j++) begin
            col = {s[0][j], s[1][j], s[2][j], s[3][j], s[4][j]};
            sb  = SBOX[col];
            for (int i = 0; i < 5; i++) o[i][j] = sb[4-i];
        end
        o[0] = o[0] ^ rotr(o[0], 19) ^ rotr(o[0], 28);
        o[1] = o[1] ^ rotr(o[1], 61) ^ rotr(o[1], 39);
        o[2] = o[2] ^ rotr(o[2], 1)  ^ rotr(o[2], 6);
        o[3] = o[3] ^ rotr(o[3], 10) ^ rotr(o[3], 17);
        o[4] = o[4] ^ rotr(o[4], 7)  ^ rotr(o[4], 41);
        return o;
    endfunction

    function automatic gst_t g_perm(input gst_t s, input int nr);
        for (int r = 12 - nr; r < 12; r++) s = g_round(s, r);
        return s;
    endfunction

    function automatic int nr_of(input logic [1:0] sel);
        case (sel)
            2'b01:   return 8;
            2'b10:   return 6;
            default: return 12;
        endcase
    endfunction

    function automatic gst_t rand_state();
        gst_t s;
        for (int i = 0; i < 5; i++) s[i] = {$urandom, $urandom};
        return s;
    endfunction

    // output monitors, sampled on the falling edge
    logic ov1_prev = 1'b0, ov2_prev = 1'b0, rdy1_pend = 1'b0, rdy2_pend = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            ov1_prev = 1'b0;
            rdy1_pend = 1'b0;
        end else begin
            if (rdy1_pend) check("u1_ready_after_out", W'(bi1.in_ready_o), W'(1));
            rdy1_pend = 1'b0;
            if (bi1.in_valid_i && bi1.in_ready_o) acc_q1.push_back(cyc);
            if (bi1.out_valid_o && !ov1_prev) begin
                if (acc_q1.size() == 0 || lat_q1.size() == 0) check("u1_unexpected_out", W'(1), W'(0));
                else check("u1_latency", W'(cyc - acc_q1.pop_front()), W'(lat_q1.pop_front()));
            end
            if (bi1.out_valid_o && bi1.out_ready_i) begin
                if (exp_q1.size() == 0) check("u1_unexpected_result", W'(1), W'(0));
                else check("u1_result", {bi1.x4_o, bi1.x3_o, bi1.x2_o, bi1.x1_o, bi1.x0_o}, exp_q1.pop_front());
                rdy1_pend = 1'b1;
            end
            ov1_prev = bi1.out_valid_o;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            ov2_prev = 1'b0;
            rdy2_pend = 1'b0;
        end else begin
            if (rdy2_pend) check("u2_ready_after_out", W'(bi2.in_ready_o), W'(1));
            rdy2_pend = 1'b0;
            if (bi2.in_valid_i && bi2.in_ready_o) acc_q2.push_back(cyc);
            if (bi2.out_valid_o && !ov2_prev) begin
                if (acc_q2.size() == 0 || lat_q2.size() == 0) check("u2_unexpected_out", W'(1), W'(0));
                else check("u2_latency", W'(cyc - acc_q2.pop_front()), W'(lat_q2.pop_front()));
            end
            if (bi2.out_valid_o && bi2.out_ready_i) begin
                if (exp_q2.size() == 0) check("u2_unexpected_result", W'(1), W'(0));
                else check("u2_result", {bi2.x4_o, bi2.x3_o, bi2.x2_o, bi2.x1_o, bi2.x0_o}, exp_q2.pop_front());
                rdy2_pend = 1'b1;
            end
            ov2_prev = bi2.out_valid_o;
        end
    end

    // driver tasks; all start and end just after a rising edge
    task automatic set_in(input logic [1:0] sel, input gst_t s);
        bi1.rounds_sel_i = sel;  bi2.rounds_sel_i = sel;
        bi1.x0_i = s[0]; bi1.x1_i = s[1]; bi1.x2_i = s[2]; bi1.x3_i = s[3]; bi1.x4_i = s[4];
        bi2.x0_i = s[0]; bi2.x1_i = s[1]; bi2.x2_i = s[2]; bi2.x3_i = s[3]; bi2.x4_i = s[4];
    endtask

    task automatic clear_sb();
        exp_q1.delete(); exp_q2.delete(); lat_q1.delete(); lat_q2.delete();
        acc_q1.delete(); acc_q2.delete();
    endtask

    task automatic reset_checks(input string tag, input logic [1:0] st, input logic rdy, input logic ov,
                                input logic bsy, input logic [W-1:0] xo);
        check({tag, "_state"}, W'(st), W'(0));
        check({tag, "_in_ready"}, W'(rdy), W'(0));
        check({tag, "_out_valid"}, W'(ov), W'(0));
        check({tag, "_busy"}, W'(bsy), W'(0));
        check({tag, "_x_out"}, xo, W'(0));
    endtask

    task automatic do_reset(input int n);
        clear_sb();
        rst = 1'b1;
        repeat (n) begin @(posedge clk); #1; end
        @(negedge clk);
        reset_checks("rst_u1", st1, bi1.in_ready_o, bi1.out_valid_o, bi1.busy_o,
                     {bi1.x4_o, bi1.x3_o, bi1.x2_o, bi1.x1_o, bi1.x0_o});
        reset_checks("rst_u2", st2, bi2.in_ready_o, bi2.out_valid_o, bi2.busy_o,
                     {bi2.x4_o, bi2.x3_o, bi2.x2_o, bi2.x1_o, bi2.x0_o});
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_release_u1_ready", W'(bi1.in_ready_o), W'(1));
        check("rst_release_u2_ready", W'(bi2.in_ready_o), W'(1));
        @(posedge clk); #1;
    endtask

    task automatic run_job(input logic [1:0] sel, input gst_t s, input bit use2, input bit expect_res);
        int n;
        int budget;
        bit p1, p2;
        n = nr_of(sel);
        if (expect_res) begin
            exp_q1.push_back(g_perm(s, n));
            lat_q1.push_back(n + 1);
            if (use2) begin
                exp_q2.push_back(g_perm(s, n));
                lat_q2.push_back(n / 2 + 1);
            end
        end
        set_in(sel, s);
        bi1.in_valid_i = 1'b1;
        bi2.in_valid_i = use2;
        budget = 0;
        while ((bi1.in_valid_i || bi2.in_valid_i) && budget < 100) begin
            @(negedge clk);
            p1 = bi1.in_valid_i && bi1.in_ready_o;
            p2 = bi2.in_valid_i && bi2.in_ready_o;
            @(posedge clk); #1;
            if (p1) bi1.in_valid_i = 1'b0;
            if (p2) bi2.in_valid_i = 1'b0;
            budget++;
        end
        if (bi1.in_valid_i || bi2.in_valid_i) begin
            check("accept_timeout", W'(1), W'(0));
            bi1.in_valid_i = 1'b0;
            bi2.in_valid_i = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int b;
        b = 0;
        while ((exp_q1.size() != 0 || exp_q2.size() != 0) && b < 200) begin
            @(posedge clk); #1;
            b++;
        end
        if (exp_q1.size() != 0 || exp_q2.size() != 0) begin
            check("drain_timeout", W'(exp_q1.size() + exp_q2.size()), W'(0));
            clear_sb();
        end
        repeat (2) begin @(posedge clk); #1; end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        gst_t s, snap_s;
        logic [W-1:0] snap;
        int b, prev, got;
        bit p1;

        bi1.in_valid_i = 1'b0; bi2.in_valid_i = 1'b0;
        bi1.out_ready_i = 1'b1; bi2.out_ready_i = 1'b1;
        set_in(2'b00, '0);
        do_reset(2);

        // fixed p12 vector
        s[0] = 64'h80400c0600000000;
        s[1] = 64'h0001020304050607;
        s[2] = 64'h08090a0b0c0d0e0f;
        s[3] = 64'h0;
        s[4] = 64'h0;
        run_job(2'b00, s, 1'b1, 1'b1);
        wait_drain();

        // p8 / p6 on random state
        for (int i = 0; i < 4; i++) begin
            run_job((i % 2 == 1) ? 2'b10 : 2'b01, rand_state(), 1'b1, 1'b1);
            wait_drain();
        end

        // consumer stall in DONE
        bi1.out_ready_i = 1'b0; bi2.out_ready_i = 1'b0;
        run_job(2'b01, rand_state(), 1'b1, 1'b1);
        b = 0;
        while (!bi1.out_valid_o && b < 50) begin @(posedge clk); #1; b++; end
        check("stall_reached_done", W'(bi1.out_valid_o), W'(1));
        snap = {bi1.x4_o, bi1.x3_o, bi1.x2_o, bi1.x1_o, bi1.x0_o};
        repeat (20) begin
            @(negedge clk);
            check("stall_out_valid", W'(bi1.out_valid_o), W'(1));
            check("stall_data", {bi1.x4_o, bi1.x3_o, bi1.x2_o, bi1.x1_o, bi1.x0_o}, snap);
            check("stall_in_ready", W'(bi1.in_ready_o), W'(0));
            check("stall_state", W'(st1), W'(2));
        end
        @(posedge clk); #1;
        bi1.out_ready_i = 1'b1; bi2.out_ready_i = 1'b1;
        wait_drain();

        // reset in the middle of a p12 job, then a clean p6 job
        run_job(2'b00, rand_state(), 1'b1, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        check("midrun_busy", W'(bi1.busy_o), W'(1));
        check("midrun_state", W'(st1), W'(1));
        @(posedge clk); #1;
        do_reset(1);
        run_job(2'b10, rand_state(), 1'b1, 1'b1);
        wait_drain();

        // sel=11 aliases p12; new requests during RUN are ignored
        run_job(2'b11, rand_state(), 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            set_in(2'(i), rand_state());
            bi1.in_valid_i = (i % 2 == 0);
            bi2.in_valid_i = (i % 2 == 0);
            @(posedge clk); #1;
        end
        bi1.in_valid_i = 1'b0; bi2.in_valid_i = 1'b0;
        wait_drain();

        // back-to-back p6 on the UNROLL=1 instance
        prev = -1;
        got = 0;
        b = 0;
        s = rand_state();
        exp_q1.push_back(g_perm(s, 6));
        lat_q1.push_back(7);
        set_in(2'b10, s);
        bi1.in_valid_i = 1'b1;
        while (got < 5 && b < 200) begin
            @(negedge clk);
            p1 = bi1.in_valid_i && bi1.in_ready_o;
            if (p1) begin
                if (prev >= 0) check("b2b_spacing", W'(cyc - prev), W'(8));
                prev = cyc;
                got++;
            end
            @(posedge clk); #1;
            b++;
            if (p1) begin
                if (got < 5) begin
                    s = rand_state();
                    exp_q1.push_back(g_perm(s, 6));
                    lat_q1.push_back(7);
                    set_in(2'b10, s);
                end else begin
                    bi1.in_valid_i = 1'b0;
                end
            end
        end
        if (got < 5) begin
            check("b2b_accept_count", W'(got), W'(5));
            bi1.in_valid_i = 1'b0;
            clear_sb();
        end
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
